seg_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the 6-digit common-anode seven-segment display.
- Owns the shared segment bus `dig` and the active-low digit strobes `sel`. Steps through digits 0..5 with a programmable slot time and an anti-ghosting blank interval.
- Takes BCD values through a valid/ready update port into a shadow buffer. The shadow is committed atomically at frame start, so a displayed frame never mixes old and new digits.

---
 rtl/seg_scan_pkg.sv | 20 ++
 rtl/seg_font.sv | 23 ++
 rtl/seg_scan_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants, segment font and scan state type for the seven-segment scan controller.
package seg_scan_pkg;

  localparam int NUM_DIG = 6;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;

  // Active-low segment patterns for BCD 0..9, bit7 (dp) off
  localparam logic [7:0] FONT [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  typedef enum logic {
    BLANK,
    DRIVE
  } scan_state_t;

endpackage

// File: rtl/seg_font.sv
// Combinational map of a 4-bit code, blank flag and decimal point to active-low segments.
module seg_font
  import seg_scan_pkg::*;
(
  input  logic [3:0] code,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [6:0] base;

  always_comb begin
    base = SEG_MINUS[6:0];
    if (blank) begin
      base = SEG_BLANK[6:0];
    end else if (code < 4'd10) begin
      base = FONT[code][6:0];
    end
    seg = {~dp, base};
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Six-digit multiplexed seven-segment scan controller with frame-atomic shadow updates.
// Define SEG_SCAN_DIM_EN to add the `bright` input and PWM dimming of the digit strobes.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [23:0] upd_bcd,
  input  logic [5:0]  upd_dp,
`ifdef SEG_SCAN_DIM_EN
  input  logic [3:0]  bright,
`endif
  input  logic        lzs_en,
  output logic [5:0]  sel,
  output logic [7:0]  dig,
  output logic        frame_start
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  scan_state_t          state_q, state_d;
  logic [4*NUM_DIG-1:0] active_bcd_q, active_bcd_d;
  logic [NUM_DIG-1:0]   active_dp_q, active_dp_d;
  logic [4*NUM_DIG-1:0] shadow_bcd_q, shadow_bcd_d;
  logic [NUM_DIG-1:0]   shadow_dp_q, shadow_dp_d;
  logic                 pending_q, pending_d;
  logic [NUM_DIG-1:0]   sel_q, sel_d;
  logic [7:0]           dig_q, dig_d;
  logic                 frame_start_q, frame_start_d;

  logic                 wrap;
  logic                 commit_cyc;
  logic                 transfer;
  logic                 gate_on;
  logic                 zero_run;
  logic [NUM_DIG-1:0]   blank_mask;
  logic [3:0]           cur_code;
  logic                 cur_dp;
  logic                 cur_blank;
  logic [7:0]           font_seg;

`ifdef SEG_SCAN_DIM_EN
  logic [3:0] pwm_cnt_q, pwm_cnt_d;
  logic [3:0] shadow_bright_q, shadow_bright_d;
  logic [3:0] active_bright_q, active_bright_d;
`endif

  assign wrap       = (cnt_q == CNT_LAST);
  assign commit_cyc = wrap && (idx_q == 3'd5);
  assign transfer   = upd_valid && !pending_q;

  assign cur_code  = active_bcd_q[{idx_q, 2'b00} +: 4];
  assign cur_dp    = active_dp_q[idx_q];
  assign cur_blank = blank_mask[idx_q];

`ifdef SEG_SCAN_DIM_EN
  assign gate_on = (pwm_cnt_q <= active_bright_q);
`else
  assign gate_on = 1'b1;
`endif

  // Blank a run of zeros from the top digit down; digit 0 always shows
  always_comb begin
    zero_run   = 1'b1;
    blank_mask = '0;
    for (int i = NUM_DIG - 1; i >= 1; i--) begin
      zero_run      = zero_run && (active_bcd_q[i*4 +: 4] == 4'd0);
      blank_mask[i] = lzs_en && zero_run;
    end
  end

  seg_font u_font (
    .code  (cur_code),
    .blank (cur_blank),
    .dp    (cur_dp),
    .seg   (font_seg)
  );

  always_comb begin
    cnt_d         = wrap ? '0 : cnt_q + 1'b1;
    idx_d         = idx_q;
    state_d       = state_q;
    active_bcd_d  = active_bcd_q;
    active_dp_d   = active_dp_q;
    shadow_bcd_d  = shadow_bcd_q;
    shadow_dp_d   = shadow_dp_q;
    pending_d     = pending_q;
    frame_start_d = commit_cyc;
    sel_d         = '1;
    dig_d         = SEG_BLANK;
`ifdef SEG_SCAN_DIM_EN
    pwm_cnt_d       = pwm_cnt_q + 4'd1;
    shadow_bright_d = shadow_bright_q;
    active_bright_d = active_bright_q;
`endif

    if (wrap) begin
      idx_d   = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      state_d = BLANK;
    end else if (cnt_q == BLANK_LAST) begin
      state_d = DRIVE;
    end

    // Commit only what was pending before this cycle; a same-cycle transfer waits a frame
    if (commit_cyc && pending_q) begin
      active_bcd_d = shadow_bcd_q;
      active_dp_d  = shadow_dp_q;
      pending_d    = 1'b0;
`ifdef SEG_SCAN_DIM_EN
      active_bright_d = shadow_bright_q;
`endif
    end

    if (transfer) begin
      shadow_bcd_d = upd_bcd;
      shadow_dp_d  = upd_dp;
      pending_d    = 1'b1;
`ifdef SEG_SCAN_DIM_EN
      shadow_bright_d = bright;
`endif
    end

    if ((state_q == DRIVE) && gate_on) begin
      sel_d[idx_q] = 1'b0;
      dig_d        = font_seg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q         <= '0;
      idx_q         <= 3'd0;
      state_q       <= BLANK;
      active_bcd_q  <= '0;
      active_dp_q   <= '0;
      shadow_bcd_q  <= '0;
      shadow_dp_q   <= '0;
      pending_q     <= 1'b0;
      sel_q         <= '1;
      dig_q         <= SEG_BLANK;
      frame_start_q <= 1'b0;
`ifdef SEG_SCAN_DIM_EN
      pwm_cnt_q       <= 4'd0;
      shadow_bright_q <= 4'hF;
      active_bright_q <= 4'hF;
`endif
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      state_q       <= state_d;
      active_bcd_q  <= active_bcd_d;
      active_dp_q   <= active_dp_d;
      shadow_bcd_q  <= shadow_bcd_d;
      shadow_dp_q   <= shadow_dp_d;
      pending_q     <= pending_d;
      sel_q         <= sel_d;
      dig_q         <= dig_d;
      frame_start_q <= frame_start_d;
`ifdef SEG_SCAN_DIM_EN
      pwm_cnt_q       <= pwm_cnt_d;
      shadow_bright_q <= shadow_bright_d;
      active_bright_q <= active_bright_d;
`endif
    end
  end

  assign upd_ready   = !pending_q;
  assign sel         = sel_q;
  assign dig         = dig_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl (SCAN_DIV = 8, BLANK_CYC = 2).
// With SEG_SCAN_DIM_EN defined a second instance (SCAN_DIV = 34) checks PWM dimming.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        reset_n;
  logic        upd_valid;
  logic        upd_ready;
  logic [23:0] upd_bcd;
  logic [5:0]  upd_dp;
  logic        lzs_en;
  logic [5:0]  sel;
  logic [7:0]  dig;
  logic        frame_start;
  logic [3:0]  bright;

  int checks;
  int failures;
  int n;
  int lows;

  seg_scan_ctrl #(
    .SCAN_DIV  (8),
    .BLANK_CYC (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .upd_bcd     (upd_bcd),
    .upd_dp      (upd_dp),
`ifdef SEG_SCAN_DIM_EN
    .bright      (bright),
`endif
    .lzs_en      (lzs_en),
    .sel         (sel),
    .dig         (dig),
    .frame_start (frame_start)
  );

`ifdef SEG_SCAN_DIM_EN
  logic       upd_ready_dim;
  logic [5:0] sel_dim;
  logic [7:0] dig_dim;
  logic       frame_start_dim;

  seg_scan_ctrl #(
    .SCAN_DIV  (34),
    .BLANK_CYC (2)
  ) dut_dim (
    .clk         (clk),
    .reset_n     (reset_n),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready_dim),
    .upd_bcd     (upd_bcd),
    .upd_dp      (upd_dp),
    .bright      (bright),
    .lzs_en      (lzs_en),
    .sel         (sel_dim),
    .dig         (dig_dim),
    .frame_start (frame_start_dim)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to edge number t after reset release, sampling 1 time unit past the edge
  task automatic runTo(input int t);
    while (n < t) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [23:0] b, input logic [5:0] d);
    upd_valid = v;
    upd_bcd   = b;
    upd_dp    = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    n        = 0;
    reset_n  = 1'b0;
    lzs_en   = 1'b0;
    bright   = 4'hF;
    applyStimulus(1'b0, 24'h0, 6'h0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_sel", sel, 6'h3F);
    checkOutput("rst_dig", dig, 8'hFF);
    checkOutput("rst_ready", upd_ready, 1'b1);
    checkOutput("rst_fs", frame_start, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;

    $display("[TB] scan timing");
    runTo(2);   checkOutput("blank_first", sel, 6'h3F);
    runTo(3);   checkOutput("drive0_sel", sel, 6'h3E);
                checkOutput("drive0_dig", dig, 8'hC0);
    runTo(8);   checkOutput("drive0_last", sel, 6'h3E);
    runTo(9);   checkOutput("blank_slot1", sel, 6'h3F);
    runTo(11);  checkOutput("drive1_sel", sel, 6'h3D);
                checkOutput("drive1_dig", dig, 8'hC0);
    runTo(16);
    lows = 0;
    for (int i = 17; i <= 24; i++) begin
      runTo(i);
      if (sel !== 6'h3F) lows++;
    end
    checkOutput("slot_drive_len", lows, 6);
    runTo(47);  checkOutput("fs_before", frame_start, 1'b0);
    runTo(48);  checkOutput("fs_first", frame_start, 1'b1);
    runTo(49);  checkOutput("fs_after", frame_start, 1'b0);
    runTo(96);  checkOutput("fs_second", frame_start, 1'b1);

    $display("[TB] mid-frame update");
    runTo(100); applyStimulus(1'b1, 24'h123456, 6'b000100);
    runTo(101); checkOutput("upd_ready_low", upd_ready, 1'b0);
                applyStimulus(1'b0, 24'h0, 6'h0);
    runTo(115); checkOutput("old_d2_sel", sel, 6'h3B);
                checkOutput("old_d2_dig", dig, 8'hC0);
    runTo(143); checkOutput("ready_until_commit", upd_ready, 1'b0);
    runTo(144); checkOutput("ready_after_commit", upd_ready, 1'b1);
    runTo(147); checkOutput("new_d0_sel", sel, 6'h3E);
                checkOutput("new_d0_dig", dig, 8'h82);
    runTo(155); checkOutput("new_d1_dig", dig, 8'h92);
    runTo(163); checkOutput("new_d2_sel", sel, 6'h3B);
                checkOutput("new_d2_dig_dp", dig, 8'h19);
    runTo(187); checkOutput("new_d5_sel", sel, 6'h1F);
                checkOutput("new_d5_dig", dig, 8'hF9);

    $display("[TB] back-to-back updates");
    runTo(200); applyStimulus(1'b1, 24'h111111, 6'h0);
    runTo(201); checkOutput("b2b_first_taken", upd_ready, 1'b0);
                applyStimulus(1'b1, 24'h222222, 6'h0);
    runTo(239); checkOutput("b2b_stall", upd_ready, 1'b0);
    runTo(240); checkOutput("b2b_commit_ready", upd_ready, 1'b1);
    runTo(241); checkOutput("b2b_second_taken", upd_ready, 1'b0);
                applyStimulus(1'b0, 24'h0, 6'h0);
    runTo(243); checkOutput("b2b_f1_d0", dig, 8'hF9);
    runTo(267); checkOutput("b2b_f1_d3", dig, 8'hF9);
    runTo(283); checkOutput("b2b_f1_d5", dig, 8'hF9);
    runTo(288); checkOutput("b2b_ready_again", upd_ready, 1'b1);
    runTo(291); checkOutput("b2b_f2_d0", dig, 8'hA4);
    runTo(315); checkOutput("b2b_f2_d3_sel", sel, 6'h37);
                checkOutput("b2b_f2_d3_dig", dig, 8'hA4);

    $display("[TB] leading-zero suppression");
    runTo(320); applyStimulus(1'b1, 24'h000070, 6'h0);
                lzs_en = 1'b1;
    runTo(321); applyStimulus(1'b0, 24'h0, 6'h0);
    runTo(339); checkOutput("lzs70_d0", dig, 8'hC0);
    runTo(347); checkOutput("lzs70_d1", dig, 8'hF8);
    runTo(355); checkOutput("lzs70_d2_sel", sel, 6'h3B);
                checkOutput("lzs70_d2", dig, 8'hFF);
    runTo(363); checkOutput("lzs70_d3", dig, 8'hFF);
    runTo(379); checkOutput("lzs70_d5_sel", sel, 6'h1F);
                checkOutput("lzs70_d5", dig, 8'hFF);
    runTo(380); applyStimulus(1'b1, 24'h000000, 6'h0);
    runTo(381); applyStimulus(1'b0, 24'h0, 6'h0);
    runTo(387); checkOutput("lzs0_d0", dig, 8'hC0);
    runTo(395); checkOutput("lzs0_d1", dig, 8'hFF);
    runTo(427); checkOutput("lzs0_d5", dig, 8'hFF);

    $display("[TB] hex code and commit-cycle transfer");
    runTo(436); applyStimulus(1'b1, 24'h00B000, 6'h0);
                lzs_en = 1'b0;
    runTo(437); applyStimulus(1'b0, 24'h0, 6'h0);
    runTo(483); checkOutput("hex_d0", dig, 8'hC0);
    runTo(507); checkOutput("hex_d3_sel", sel, 6'h37);
                checkOutput("hex_d3_minus", dig, 8'hBF);
    runTo(523); checkOutput("hex_d5_nolzs", dig, 8'hC0);
    runTo(527); applyStimulus(1'b1, 24'h999999, 6'h0);
    runTo(528); checkOutput("cc_fs", frame_start, 1'b1);
                checkOutput("cc_taken", upd_ready, 1'b0);
                applyStimulus(1'b0, 24'h0, 6'h0);
    runTo(555); checkOutput("cc_not_current", dig, 8'hBF);
    runTo(579); checkOutput("cc_next_frame", dig, 8'h90);

    $display("[TB] reset mid-drive");
    runTo(580); applyStimulus(1'b1, 24'h777777, 6'h0);
    runTo(581); applyStimulus(1'b0, 24'h0, 6'h0);
    runTo(589); checkOutput("pre_rst_sel", sel, 6'h3D);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_sel", sel, 6'h3F);
    checkOutput("midrst_dig", dig, 8'hFF);
    checkOutput("midrst_ready", upd_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    runTo(3);   checkOutput("post_rst_d0", dig, 8'hC0);
    runTo(50);  checkOutput("post_rst_ready", upd_ready, 1'b1);
    runTo(51);  checkOutput("discard_sel", sel, 6'h3E);
                checkOutput("discard_dig", dig, 8'hC0);

`ifdef SEG_SCAN_DIM_EN
    $display("[TB] pwm dimming");
    runTo(60);  bright = 4'd3;
                applyStimulus(1'b1, 24'h000000, 6'h0);
    runTo(61);  applyStimulus(1'b0, 24'h0, 6'h0);
    runTo(238);
    lows = 0;
    for (int i = 239; i <= 272; i++) begin
      runTo(i);
      if (sel_dim !== 6'h3F) lows++;
    end
    checkOutput("dim_b3_low", lows, 8);
    runTo(280); bright = 4'd15;
                applyStimulus(1'b1, 24'h000000, 6'h0);
    runTo(281); applyStimulus(1'b0, 24'h0, 6'h0);
    runTo(442);
    lows = 0;
    for (int i = 443; i <= 476; i++) begin
      runTo(i);
      if (sel_dim !== 6'h3F) lows++;
    end
    checkOutput("dim_b15_low", lows, 32);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
